// File: rtl/carcontrol_nios2_mulx_pkg.sv
// Shared definitions for the multi-cycle MUL/MULX sequencer: op encodings,
// FSM states, the operand request record and the fixed start-to-done latency.
package carcontrol_nios2_mulx_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  localparam int LATENCY = 7;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, DONE} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } mulx_req_t;

endpackage

// File: rtl/carcontrol_nios2_mul16_cell.sv
// Registered 16x16 unsigned multiplier, always enabled, async-cleared output.
module carcontrol_nios2_mul16_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= '0;
    else          p <= 32'(a) * 32'(b);
  end

endmodule

// File: rtl/carcontrol_nios2_mulx_seq.sv
// 32x32 multiply sequencer: four 16x16 partial products through one registered
// cell, 64-bit accumulate, then signed high-word correction when
// CARCTL_MULX_SIGNED_EN is defined (otherwise signed ops return the MULXUU word).
module carcontrol_nios2_mulx_seq
  import carcontrol_nios2_mulx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        kill,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state, state_nx;
  mulx_req_t   req;
  logic [1:0]  k;
  logic [63:0] acc;
  logic [63:0] pp_w;
  logic [31:0] corr;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        accept;

  assign accept = start && !kill && (state == IDLE || state == DONE);

  carcontrol_nios2_mul16_cell u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (mul_a),
    .b       (mul_b),
    .p       (mul_p)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (kill) state_nx = IDLE;
    else begin
      case (state)
        IDLE, DONE: state_nx = start ? ISSUE : IDLE;
        ISSUE:      if (k == 2'd3) state_nx = DRAIN;
        DRAIN:      state_nx = CORR;
        CORR:       state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  // k selects halves: bit0 picks aH, bit1 picks bH -> p0,p1,p2,p3 in order
  always_comb begin
    busy  = (state == ISSUE) || (state == DRAIN) || (state == CORR);
    done  = (state == DONE);
    mul_a = k[0] ? req.a[31:16] : req.a[15:0];
    mul_b = k[1] ? req.b[31:16] : req.b[15:0];
  end

  // The cell output holds p(k-1); in DRAIN k has wrapped to 0 so k-1 = 3.
  always_comb begin
    case (k - 2'd1)
      2'd0:    pp_w = {32'd0, mul_p};
      2'd3:    pp_w = {mul_p, 32'd0};
      default: pp_w = {16'd0, mul_p, 16'd0};
    endcase
  end

  always_comb begin
    corr = acc[63:32];
    if (req.op == OP_MUL) corr = acc[31:0];
`ifdef CARCTL_MULX_SIGNED_EN
    else begin
      if ((req.op == OP_MULXSU || req.op == OP_MULXSS) && req.a[31]) corr = corr - req.b;
      if (req.op == OP_MULXSS && req.b[31])                          corr = corr - req.a;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req    <= '0;
      k      <= '0;
      acc    <= '0;
      result <= '0;
    end else if (accept) begin
      req <= '{op: op, a: src1, b: src2};
      k   <= '0;
      acc <= '0;
    end else if (!kill) begin
      case (state)
        ISSUE: begin
          k <= k + 2'd1;
          if (k != 2'd0) acc <= acc + pp_w;
        end
        DRAIN:   acc <= acc + pp_w;
        CORR:    result <= corr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carcontrol_nios2_mulx_seq.sv
// Directed bench for the MUL/MULX sequencer: back-to-back vector table plus
// hand sequences for ignored start, kill, kill-with-start and async reset.
module tb_carcontrol_nios2_mulx_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  carcontrol_nios2_mulx_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

`ifdef CARCTL_MULX_SIGNED_EN
  localparam logic [31:0] SGN_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SGN_EXP = 32'h0000_0001;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge that is cycle 0; returns at the negedge of cycle 7
  // with start low. poke_c>0 pulses an unrelated start in that cycle.
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string nm, input int poke_c);
    op = o; src1 = a; src2 = b; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("%s busy c%0d", nm, c), {31'd0, busy}, {31'd0, c <= 6});
      chk($sformatf("%s done c%0d", nm, c), {31'd0, done}, {31'd0, c == 7});
      if (c == poke_c) begin
        start = 1'b1; op = 2'b00; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
      end else begin
        start = 1'b0; src1 = ~a; src2 = ~b;
      end
    end
    chk({nm, " result"}, result, exp);
  endtask

  vec_t vt[5];
  logic [31:0] held;

  initial begin
    vt[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "mul_basic"};
    vt[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulxuu_max"};
    vt[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max"};
    vt[3] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, SGN_EXP,       "mulxss"};
    vt[4] = '{2'b10, 32'h8000_0000, 32'h0000_0002, SGN_EXP,       "mulxsu"};

    repeat (2) @(negedge clk);
    chk("reset busy",   {31'd0, busy}, 32'd0);
    chk("reset done",   {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each next start is asserted in the previous DONE cycle.
    for (int i = 0; i < 5; i++) run(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].nm, 0);
    @(negedge clk);

    // Start during busy must be ignored and operands not re-sampled.
    run(2'b01, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, "ign_start", 3);
    @(negedge clk);

    // Kill in cycle 4: idle in cycle 5, no done, result kept.
    held = result;
    op = 2'b00; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("kill busy c5", {31'd0, busy}, 32'd0);
    for (int c = 5; c <= 9; c++) begin
      chk($sformatf("kill done c%0d", c), {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk("kill result held", result, held);
    run(2'b00, 32'd7, 32'd9, 32'd63, "after_kill", 0);
    @(negedge clk);

    // kill with start in IDLE: not accepted.
    start = 1'b1; kill = 1'b1;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    chk("kill+start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // Async reset in cycle 2 clears outputs; no done afterwards.
    op = 2'b01; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0; #1;
    chk("rst busy",   {31'd0, busy}, 32'd0);
    chk("rst done",   {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst done c%0d", c), {31'd0, done}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
